pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush/forward controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
//  Drives the stall and flush inputs of every inter-stage pipeline register.
//  Resolves load-use RAW hazards, taken-branch flushes and multi-cycle data-memory/UART waits.
//  Sits beside the datapath; all hazard decisions go through this block.
// PARAMETERS
//  REG_AW  5   register-file address width
//  CNT_W   16  width of the saturating stall-cycle counter
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-low
//  id_rs1       in   REG_AW  ID-stage source register 1
//  id_rs2       in   REG_AW  ID-stage source register 2
//  id_rs1_used  in   1       ID instruction reads rs1
//  id_rs2_used  in   1       ID instruction reads rs2
//  ex_rd        in   REG_AW  EX-stage destination register
//  ex_regwrite  in   1       EX instruction writes rd
//  ex_memread   in   1       EX instruction is a load
//  mem_rd       in   REG_AW  MEM-stage destination register
//  mem_regwrite in   1       MEM instruction writes rd
//  wb_rd        in   REG_AW  WB-stage destination register
//  wb_regwrite  in   1       WB instruction writes rd
//  br_taken     in   1       EX branch/jump resolved taken (one-cycle pulse)
//  dmem_req     in   1       MEM stage starts a data-memory/UART access
//  dmem_ready   in   1       access complete (may be the same cycle as dmem_req)
//  stall_pc     out  1       hold PC
//  stall_ifid   out  1       hold IF/ID register
//  stall_idex   out  1       hold ID/EX register
//  stall_exmem  out  1       hold EX/MEM register
//  flush_ifid   out  1       clear IF/ID register to NOP
//  flush_idex   out  1       clear ID/EX register to NOP (bubble)
//  fwd_a        out  2       EX operand A select: 00=RF, 01=WB, 10=MEM
//  fwd_b        out  2       EX operand B select, same encoding
//  stall_cnt    out  CNT_W   stall cycles since reset, saturating
// BEHAVIOUR
//  - rd==0 never causes a hazard or a forward.
//  - Stall/flush/fwd outputs are combinational from inputs and state. FSM, pending flag and counter are registered.
//  - Reset (rst=0 at posedge): state=RUN, br_pend=0, stall_cnt=0.
//    While rst=0, all stalls are 0, flush_ifid=flush_idex=1 and fwd=00.
//  - FSM RUN:
//    - dmem_req & !dmem_ready -> MEM_WAIT.
//    - All other cases stay in RUN.
//  - FSM MEM_WAIT:
//    - Asserts stall_pc, stall_ifid, stall_idex and stall_exmem. No flushes.
//    - dmem_ready -> RUN, releasing the stalls in the same cycle.
//  - br_taken while in MEM_WAIT sets br_pend. The flush is applied in the first RUN cycle, then br_pend clears.
//  - RUN, no wait: branch flush = br_taken | br_pend -> flush_ifid=1, flush_idex=1, no stalls.
//  - RUN, load-use = ex_memread & ex_regwrite & ex_rd!=0 & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)):
//    stall_pc=1, stall_ifid=1, flush_idex=1, for exactly one cycle.
//  - Priority: MEM_WAIT > branch flush > load-use > RAW stall. A branch together with load-use gives flush only.
//  - stall_cnt += 1 on each cycle with stall_pc=1, saturating at all-ones.
// CONFIGURATION
//  - Macro HAZARD_FWD_EN defined:
//    - Forwarding unit is built. MEM source beats WB source when both match.
//    - RAW hazards other than load-use cause no stall.
//  - Macro HAZARD_FWD_EN undefined:
//    - fwd_a=fwd_b=00 constant.
//    - A match of rs1/rs2 against ex_rd, mem_rd or wb_rd (with the matching regwrite set, rd!=0) is a RAW stall.
//      RAW stall is handled exactly as load-use: stall_pc, stall_ifid and flush_idex, repeated each cycle until no match.
//    - The register file writes first and reads second, so a WB match is not a hazard.
// STRUCTURE
//  - Package hazard_pkg: typedef enum logic {RUN, MEM_WAIT} hz_state_t; localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
//  - One sub-module, fwd_unit: combinational forward select. Instantiated only under HAZARD_FWD_EN.
// TESTING
//  - Reset: hold rst=0 for 2 cycles -> flush_ifid=flush_idex=1, stall_cnt=0. After release, state=RUN and outputs idle.
//  - Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle of stall_pc=stall_ifid=flush_idex=1; stall_cnt=1.
//  - Forwarding (FWD_EN): mem_rd=3, wb_rd=3, both regwrite, id_rs2=3 -> fwd_b=10. With mem_regwrite=0 -> fwd_b=01.
//  - No forwarding (FWD_EN off): ex_rd=7, ex_regwrite=1, id_rs1=7 -> stall until rd 7 leaves MEM, then release.
//  - Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles -> 3 cycles of all stalls.
//    br_taken pulse during the wait -> flush_ifid=flush_idex=1 in the first cycle after dmem_ready.
//  - Edges: rd=0 load-use -> no stall. br_taken with a load-use match -> flush only.
//    rst=0 mid-MEM_WAIT -> RUN next cycle, br_pend=0.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and encodings for the pipeline hazard
//                controller and its forwarding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Controller FSM: normal issue, or frozen on a multi-cycle data access
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_unit
//  Description : Combinational EX operand forward select. A MEM-stage
//                producer is younger than a WB-stage one, so it wins when
//                both match. Register x0 is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_regwrite,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b
);

    logic w_mem_ok;
    logic w_wb_ok;

    assign w_mem_ok = i_mem_regwrite && (i_mem_rd != '0);
    assign w_wb_ok  = i_wb_regwrite  && (i_wb_rd  != '0);

    // Operand A source: youngest matching producer first
    always_comb begin
        o_fwd_a = FWD_RF;
        if (w_mem_ok && (i_rs1 == i_mem_rd)) begin
            o_fwd_a = FWD_MEM;
        end else if (w_wb_ok && (i_rs1 == i_wb_rd)) begin
            o_fwd_a = FWD_WB;
        end
    end

    // Operand B source: same rule as operand A
    always_comb begin
        o_fwd_b = FWD_RF;
        if (w_mem_ok && (i_rs2 == i_mem_rd)) begin
            o_fwd_b = FWD_MEM;
        end else if (w_wb_ok && (i_rs2 == i_wb_rd)) begin
            o_fwd_b = FWD_WB;
        end
    end

endmodule : fwd_unit
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush/forward controller for a 5-stage RV32I pipeline.
//                Handles load-use and RAW hazards, taken-branch flushes and
//                multi-cycle data-memory waits. Branches resolved while the
//                pipe is frozen are remembered and flushed on release.
//                Build option: define HAZARD_FWD_EN to build the forwarding
//                unit; otherwise every RAW dependency stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_regwrite,
    input  logic              i_br_taken,
    input  logic              i_dmem_req,
    input  logic              i_dmem_ready,
    output logic              o_stall_pc,
    output logic              o_stall_ifid,
    output logic              o_stall_idex,
    output logic              o_stall_exmem,
    output logic              o_flush_ifid,
    output logic              o_flush_idex,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    hz_state_t          r_state;
    logic               r_br_pend;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_ex_hit;
    logic               w_load_use;
    logic               w_raw;
    logic               w_hazard;
    logic               w_branch;
    logic [1:0]         w_fwd_a;
    logic [1:0]         w_fwd_b;

    // ID source matches a live, non-x0 destination in EX
    assign w_ex_hit = i_ex_regwrite && (i_ex_rd != '0) &&
                      ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

    assign w_load_use = i_ex_memread && w_ex_hit;

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time
    assign w_raw = 1'b0;

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_unit (
        .i_rs1          (i_id_rs1),
        .i_rs2          (i_id_rs2),
        .i_mem_rd       (i_mem_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_wb_rd        (i_wb_rd),
        .i_wb_regwrite  (i_wb_regwrite),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b)
    );
`else
    logic w_mem_hit;
    logic w_unused_ok;

    // Without bypass paths any EX/MEM producer blocks the reader; WB is
    // safe because the register file writes before it reads.
    assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) &&
                       ((i_id_rs1_used && (i_id_rs1 == i_mem_rd)) ||
                        (i_id_rs2_used && (i_id_rs2 == i_mem_rd)));

    assign w_raw       = w_ex_hit || w_mem_hit;
    assign w_fwd_a     = FWD_RF;
    assign w_fwd_b     = FWD_RF;
    assign w_unused_ok = ^{i_wb_rd, i_wb_regwrite};
`endif

    assign w_hazard = w_load_use || w_raw;
    assign w_branch = i_br_taken || r_br_pend;

    // Stall/flush decode: reset > memory wait > branch > data hazard
    always_comb begin
        o_stall_pc    = 1'b0;
        o_stall_ifid  = 1'b0;
        o_stall_idex  = 1'b0;
        o_stall_exmem = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        if (!rst) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end else if (r_state == MEM_WAIT) begin
            if (!i_dmem_ready) begin
                o_stall_pc    = 1'b1;
                o_stall_ifid  = 1'b1;
                o_stall_idex  = 1'b1;
                o_stall_exmem = 1'b1;
            end else if (w_hazard) begin
                // Release cycle: branch flush is deferred via r_br_pend,
                // but a data hazard must still hold the reader back.
                o_stall_pc   = 1'b1;
                o_stall_ifid = 1'b1;
                o_flush_idex = 1'b1;
            end
        end else if (w_branch) begin
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end else if (w_hazard) begin
            o_stall_pc   = 1'b1;
            o_stall_ifid = 1'b1;
            o_flush_idex = 1'b1;
        end
    end

    assign o_fwd_a     = rst ? w_fwd_a : FWD_RF;
    assign o_fwd_b     = rst ? w_fwd_b : FWD_RF;
    assign o_stall_cnt = r_stall_cnt;

    // Controller state, pending-branch flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_br_pend   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_dmem_req && !i_dmem_ready) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (i_dmem_ready) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase

            if ((r_state == MEM_WAIT) && i_br_taken) begin
                r_br_pend <= 1'b1;
            end else if (r_state == RUN) begin
                r_br_pend <= 1'b0;
            end

            if (o_stall_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule : pipeline_hazard_ctrl
`default_nettype wire
